// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM states and stream geometry.
package loader_pkg;

  localparam int unsigned LEN_W_DEF      = 16;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_STRIDE    = 4;

  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    LOAD   = 3'd2,
    WRITE  = 3'd3,
    CHK    = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte packer: shifts bytes left into a 32-bit word.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   shift_en       shift byte_in into the low byte this cycle
//   byte_in        incoming stream byte
//   word           packed word (first byte ends up in bits 31:24)
//   count          bytes accepted into the current word (0..3)
//   full           high after the 4th shift, cleared by the next shift or reset
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic [1:0]  count,
  output logic        full
);

  logic [31:0] r_word;
  logic [1:0]  r_count;
  logic        r_full;

  // Shift register and byte counter; counter wraps naturally after 4 bytes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_word  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else if (shift_en) begin
      r_word  <= {r_word[23:0], byte_in};
      r_count <= r_count + 2'd1;
      r_full  <= (r_count == 2'(BYTES_PER_WORD - 1));
    end
  end

  assign word  = r_word;
  assign count = r_count;
  assign full  = r_full;

endmodule

// File: rtl/program_loader.sv
// Program loader: receives a length-prefixed byte stream, packs it big-endian
// into 32-bit words, writes them to instruction memory and releases the CPU
// once the whole image is in place.
// Optional feature: define PROGRAM_LOADER_CHECKSUM_EN to require a trailing
// XOR checksum byte before the CPU is released.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   byte_valid/data     stream input, transfers when byte_valid && byte_ready
//   byte_ready          loader can accept a byte (decoded from state)
//   mem_we/addr/wdata   instruction-memory write port, one pulse per word
//   cpu_hold            stalls the CPU until a successful load
//   done, error         terminal status flags
//   words_loaded        words written so far
module program_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned LEN_W     = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             cpu_hold,
  output logic             done,
  output logic             error,
  output logic [LEN_W-1:0] words_loaded
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam state_t FIN_ST = CHK;
`else
  localparam state_t FIN_ST = DONE;
`endif

  state_t           r_state, w_state_nx;
  logic [7:0]       r_len_hi;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_words;
  logic [LEN_W-1:0] w_words_inc;
  logic [LEN_W-1:0] w_len;
  logic [31:0]      r_addr;
  logic             r_we;
  logic             r_hold;
  logic             r_done;
  logic             r_error;
  logic             w_accept;
  logic             w_shift;
  logic [31:0]      w_word;
  logic [1:0]       w_count;
  logic             w_full;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]       r_csum;
`endif

  assign byte_ready  = (r_state == LEN_HI) || (r_state == LEN_LO) ||
                       (r_state == LOAD)   || (r_state == CHK);
  assign w_accept    = byte_valid && byte_ready;
  assign w_shift     = w_accept && (r_state == LOAD);
  assign w_len       = LEN_W'({r_len_hi, byte_data});
  assign w_words_inc = r_words + LEN_W'(1);

  byte_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (w_shift),
    .byte_in  (byte_data),
    .word     (w_word),
    .count    (w_count),
    .full     (w_full)
  );

  // Next-state decode.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      LEN_HI: if (w_accept) w_state_nx = LEN_LO;
      LEN_LO: begin
        if (w_accept) begin
          if (w_len == '0)                          w_state_nx = FIN_ST;
          else if (32'(w_len) > 32'(MAX_WORDS))     w_state_nx = ERR;
          else                                      w_state_nx = LOAD;
        end
      end
      LOAD:   if (w_accept && (w_count == 2'(BYTES_PER_WORD - 1))) w_state_nx = WRITE;
      WRITE:  w_state_nx = (w_words_inc < r_len) ? LOAD : FIN_ST;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHK:    if (w_accept) w_state_nx = (byte_data == r_csum) ? DONE : ERR;
`endif
      default: w_state_nx = r_state;
    endcase
  end

  // State register, registered outputs and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= LEN_HI;
      r_len_hi <= '0;
      r_len    <= '0;
      r_words  <= '0;
      r_addr   <= BASE_ADDR;
      r_we     <= 1'b0;
      r_hold   <= 1'b1;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      r_csum   <= '0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_we    <= (w_state_nx == WRITE);
      r_hold  <= (w_state_nx != DONE);
      r_done  <= (w_state_nx == DONE);
      r_error <= (w_state_nx == ERR);
      if ((r_state == LEN_HI) && w_accept) r_len_hi <= byte_data;
      if ((r_state == LEN_LO) && w_accept) r_len    <= w_len;
      if (r_state == WRITE) begin
        r_addr  <= r_addr + 32'(WORD_STRIDE);
        r_words <= w_words_inc;
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      if (w_shift) r_csum <= r_csum ^ byte_data;
`endif
    end
  end

  assign mem_we       = r_we;
  assign mem_addr     = r_addr;
  // Present the word only once all four bytes are in; zero while filling.
  assign mem_wdata    = w_full ? w_word : 32'h0;
  assign cpu_hold     = r_hold;
  assign done         = r_done;
  assign error        = r_error;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a cycle table for a 3-word load plus
// hand-written sequences for the empty, oversize, gapped, reset and checksum cases.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int n_vec  = 0;
  int n_bad  = 0;
  int we_cnt = 0;

  program_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_we === 1'b1) we_cnt++;

  typedef struct {
    logic        valid;
    logic [7:0]  data;
    logic        exp_ready;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [15:0] exp_words;
    logic        exp_done;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present one byte and hold it until accepted (bounded).
  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 16 && !ok; i++) begin
      if (byte_ready === 1'b1) ok = 1'b1;
      tick();
    end
    byte_valid = 1'b0;
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_timeout: byte %h never accepted, byte_ready=%b", b, byte_ready);
    end
  endtask

  task automatic send_csum(input logic [7:0] c);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(c);
`else
    byte_data = c;
`endif
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"},    32'(mem_we), 32'h0);
    chk({tag, "_addr"},  mem_addr, 32'h0);
    chk({tag, "_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_hold"},  32'(cpu_hold), 32'h1);
    chk({tag, "_done"},  32'(done), 32'h0);
    chk({tag, "_error"}, 32'(error), 32'h0);
    chk({tag, "_words"}, 32'(words_loaded), 32'h0);
    chk({tag, "_ready"}, 32'(byte_ready), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    // Three-word load, continuous valid; bytes offered during WRITE are held.
    tbl[0]  = '{1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,         16'd0, 1'b0};
    tbl[1]  = '{1'b1, 8'h03, 1'b1, 1'b0, 32'h0, 32'h0,         16'd0, 1'b0};
    tbl[2]  = '{1'b1, 8'h20, 1'b1, 1'b0, 32'h0, 32'h0,         16'd0, 1'b0};
    tbl[3]  = '{1'b1, 8'h11, 1'b1, 1'b0, 32'h0, 32'h0,         16'd0, 1'b0};
    tbl[4]  = '{1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,         16'd0, 1'b0};
    tbl[5]  = '{1'b1, 8'h05, 1'b1, 1'b1, 32'h0, 32'h20110005,  16'd0, 1'b0};
    tbl[6]  = '{1'b1, 8'h20, 1'b0, 1'b0, 32'h4, 32'h0,         16'd1, 1'b0};
    tbl[7]  = '{1'b1, 8'h20, 1'b1, 1'b0, 32'h4, 32'h0,         16'd1, 1'b0};
    tbl[8]  = '{1'b1, 8'h12, 1'b1, 1'b0, 32'h4, 32'h0,         16'd1, 1'b0};
    tbl[9]  = '{1'b1, 8'h00, 1'b1, 1'b0, 32'h4, 32'h0,         16'd1, 1'b0};
    tbl[10] = '{1'b1, 8'h13, 1'b1, 1'b1, 32'h4, 32'h20120013,  16'd1, 1'b0};
    tbl[11] = '{1'b1, 8'h02, 1'b0, 1'b0, 32'h8, 32'h0,         16'd2, 1'b0};
    tbl[12] = '{1'b1, 8'h02, 1'b1, 1'b0, 32'h8, 32'h0,         16'd2, 1'b0};
    tbl[13] = '{1'b1, 8'h32, 1'b1, 1'b0, 32'h8, 32'h0,         16'd2, 1'b0};
    tbl[14] = '{1'b1, 8'h80, 1'b1, 1'b0, 32'h8, 32'h0,         16'd2, 1'b0};
    tbl[15] = '{1'b1, 8'h20, 1'b1, 1'b1, 32'h8, 32'h02328020,  16'd2, 1'b0};
    tbl[16] = '{1'b1, 8'h00, 1'b0, 1'b0, 32'hC, 32'h0,         16'd3, 1'b1};
    tbl[17] = '{1'b1, 8'h00, 1'b0, 1'b0, 32'hC, 32'h0,         16'd3, 1'b1};
    tbl[18] = '{1'b1, 8'h00, 1'b0, 1'b0, 32'hC, 32'h0,         16'd3, 1'b1};
    tbl[19] = '{1'b1, 8'h08, 1'b0, 1'b0, 32'hC, 32'h0,         16'd3, 1'b1};

    do_reset();
    chk_reset_outputs("rst0");

`ifndef PROGRAM_LOADER_CHECKSUM_EN
    base = we_cnt;
    for (int i = 0; i < 20; i++) begin
      byte_valid = tbl[i].valid;
      byte_data  = tbl[i].data;
      chk($sformatf("t1_ready[%0d]", i), 32'(byte_ready), 32'(tbl[i].exp_ready));
      tick();
      chk($sformatf("t1_we[%0d]", i),    32'(mem_we), 32'(tbl[i].exp_we));
      chk($sformatf("t1_addr[%0d]", i),  mem_addr, tbl[i].exp_addr);
      chk($sformatf("t1_words[%0d]", i), 32'(words_loaded), 32'(tbl[i].exp_words));
      chk($sformatf("t1_done[%0d]", i),  32'(done), 32'(tbl[i].exp_done));
      chk($sformatf("t1_hold[%0d]", i),  32'(cpu_hold), 32'(!tbl[i].exp_done));
      chk($sformatf("t1_err[%0d]", i),   32'(error), 32'h0);
      if (tbl[i].exp_we) chk($sformatf("t1_wdata[%0d]", i), mem_wdata, tbl[i].exp_wdata);
    end
    idle(2);
    chk("t1_we_count", 32'(we_cnt - base), 32'd3);
`endif

    // Empty program: done right after the header.
    do_reset();
    base = we_cnt;
    send_byte(8'h00);
    send_byte(8'h00);
    send_csum(8'h00);
    chk("t2_done", 32'(done), 32'h1);
    chk("t2_hold", 32'(cpu_hold), 32'h0);
    idle(2);
    chk("t2_we_count", 32'(we_cnt - base), 32'd0);

    // Oversize header (1025 words).
    do_reset();
    base = we_cnt;
    send_byte(8'h04);
    send_byte(8'h01);
    chk("t3_error", 32'(error), 32'h1);
    chk("t3_hold",  32'(cpu_hold), 32'h1);
    chk("t3_ready", 32'(byte_ready), 32'h0);
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    idle(3);
    chk("t3_error_hold", 32'(error), 32'h1);
    chk("t3_done", 32'(done), 32'h0);
    chk("t3_we_count", 32'(we_cnt - base), 32'd0);

    // One word with a one-cycle gap between every byte.
    do_reset();
    base = we_cnt;
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hDE); idle(1);
    send_byte(8'hAD); idle(1);
    send_byte(8'hBE); idle(1);
    chk("t4_we_early", 32'(mem_we), 32'h0);
    send_byte(8'hEF);
    chk("t4_we",    32'(mem_we), 32'h1);
    chk("t4_addr",  mem_addr, 32'h0);
    chk("t4_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    chk("t4_we_drop", 32'(mem_we), 32'h0);
    send_csum(8'h22);
    chk("t4_done",  32'(done), 32'h1);
    chk("t4_words", 32'(words_loaded), 32'd1);
    idle(2);
    chk("t4_we_count", 32'(we_cnt - base), 32'd1);

    // Reset in the middle of the first word, then a clean reload.
    do_reset();
    base = we_cnt;
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    rst_n = 1'b0;
    tick();
    chk_reset_outputs("t5_rst");
    rst_n = 1'b1;
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    send_byte(8'hD4);
    chk("t5_we",    32'(mem_we), 32'h1);
    chk("t5_addr",  mem_addr, 32'h0);
    chk("t5_wdata", mem_wdata, 32'hA1B2C3D4);
    tick();
    send_csum(8'h04);
    chk("t5_done", 32'(done), 32'h1);
    chk("t5_hold", 32'(cpu_hold), 32'h0);
    idle(2);
    chk("t5_we_count", 32'(we_cnt - base), 32'd1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Checksum match and mismatch.
    do_reset();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h04);
    chk("t6_done",  32'(done), 32'h1);
    chk("t6_error", 32'(error), 32'h0);
    do_reset();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05);
    chk("t7_error", 32'(error), 32'h1);
    chk("t7_hold",  32'(cpu_hold), 32'h1);
    chk("t7_done",  32'(done), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
